// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor that sums CHUNK bits per clock and ripples the carry
// through a register between chunks, with valid/ready handshakes on both sides.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("chunked_serial_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry;

  // The carry into the top bit of a chunk is recovered from that bit's sum: s = a ^ b ^ c_in.
  always_comb begin
    a_chunk   = a_reg[idx*CHUNK +: CHUNK];
    b_chunk   = b_reg[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    msb_carry = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      S         <= '0;
      Cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= sub ? ~B : B;
            carry    <= sub ? 1'b1 : Cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          S[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry                 <= chunk_sum[CHUNK];
          idx                   <= idx + IDXW'(1);
          // Last chunk: publish carry-out and signed overflow alongside the final sum bits.
          if (idx == IDXW'(N-1)) begin
            Cout      <= chunk_sum[CHUNK];
            overflow  <= msb_carry ^ chunk_sum[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench: five adder configurations driven one at a time, results checked
// against a signed/unsigned arithmetic model by a negedge monitor.
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  in_valid_v;
  logic [4:0]  cin_v;
  logic [4:0]  sub_v;
  logic [4:0]  out_ready_v;
  logic [31:0] a_v [5];
  logic [31:0] b_v [5];

  logic [4:0]  in_ready_w;
  logic [4:0]  out_valid_w;
  logic [4:0]  cout_w;
  logic [4:0]  ovf_w;
  logic [31:0] s_w [5];

  logic [0:0]  s0;
  logic [7:0]  s1;
  logic [31:0] s2;
  logic [15:0] s3;
  logic [15:0] s4;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   cur       = 0;
  bit   rand_mode = 1'b0;

  always #5 clock = ~clock;

  chunked_serial_adder #(.WIDTH(1), .CHUNK(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .A(a_v[0][0:0]), .B(b_v[0][0:0]), .Cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]), .S(s0), .Cout(cout_w[0]),
    .overflow(ovf_w[0]));

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .Cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]), .S(s1), .Cout(cout_w[1]),
    .overflow(ovf_w[1]));

  chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .A(a_v[2]), .B(b_v[2]), .Cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]), .S(s2), .Cout(cout_w[2]),
    .overflow(ovf_w[2]));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .A(a_v[3][15:0]), .B(b_v[3][15:0]), .Cin(cin_v[3]), .sub(sub_v[3]),
    .out_valid(out_valid_w[3]), .out_ready(out_ready_v[3]), .S(s3), .Cout(cout_w[3]),
    .overflow(ovf_w[3]));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_w[4]),
    .A(a_v[4][15:0]), .B(b_v[4][15:0]), .Cin(cin_v[4]), .sub(sub_v[4]),
    .out_valid(out_valid_w[4]), .out_ready(out_ready_v[4]), .S(s4), .Cout(cout_w[4]),
    .overflow(ovf_w[4]));

  always_comb begin
    s_w[0] = {31'b0, s0};
    s_w[1] = {24'b0, s1};
    s_w[2] = s2;
    s_w[3] = {16'b0, s3};
    s_w[4] = {16'b0, s4};
  end

  function automatic int cfgWidth(input int k);
    case (k)
      0: return 1;
      1: return 8;
      2: return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int cfgCycles(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 8;
      3: return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: unsigned arithmetic for S/Cout, true signed arithmetic range test for overflow.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sb);
    longint one = 1;
    longint mask, ua, ub, sa, sbv, res, sres, smax, smin;
    exp_t   e;
    mask = (one << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sbv  = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    smax = (one << (w - 1)) - 1;
    smin = -(one << (w - 1));
    if (sb) begin
      res    = ua - ub;
      e.cout = (ua >= ub);
      sres   = sa - sbv;
    end else begin
      res    = ua + ub + longint'(cin);
      e.cout = ((res >> w) & 1) != 0;
      sres   = sa + sbv + longint'(cin);
    end
    e.s   = 32'(res & mask);
    e.ovf = (sres > smax) || (sres < smin);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s cfg=%0d actual=%0h required=%0h at %0t", name, cur, act, req, $time);
    end
  endtask

  // Issue one operation to configuration k and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sb, input bit push, output bit ok);
    int guard = 0;
    bit acc   = 1'b0;
    if (push) exp_q.push_back(model(cfgWidth(k), a, b, cin, sb));
    a_v[k]        = a;
    b_v[k]        = b;
    cin_v[k]      = cin;
    sub_v[k]      = sb;
    in_valid_v[k] = 1'b1;
    do begin
      @(negedge clock);
      acc = in_ready_w[k];
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 200);
    in_valid_v[k] = 1'b0;
    a_v[k]        = 32'(~a);
    b_v[k]        = 32'(~b);
    ok            = acc;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic measureLatency(input int k);
    int lat = 0;
    while (!out_valid_w[k] && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(cfgCycles(k)));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a result is consumed when out_valid && out_ready are seen ahead of the edge.
  always @(negedge clock) begin
    if (reset_n && out_valid_w[cur] && out_ready_v[cur]) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_S", s_w[cur], mon_e.s);
        checkOutput("sb_Cout", {31'b0, cout_w[cur]}, {31'b0, mon_e.cout});
        checkOutput("sb_overflow", {31'b0, ovf_w[cur]}, {31'b0, mon_e.ovf});
      end
    end
  end

  // Random consumer backpressure during the randomised phases.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) out_ready_v[cur] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit ok;
    logic [31:0] ra, rb;
    in_valid_v  = '0;
    cin_v       = '0;
    sub_v       = '0;
    out_ready_v = '1;
    for (int k = 0; k < 5; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      cur = k;
      checkOutput("reset_in_ready", {31'b0, in_ready_w[k]}, 32'd1);
      checkOutput("reset_out_valid", {31'b0, out_valid_w[k]}, 32'd0);
      checkOutput("reset_S", s_w[k], 32'd0);
      checkOutput("reset_Cout", {31'b0, cout_w[k]}, 32'd0);
      checkOutput("reset_overflow", {31'b0, ovf_w[k]}, 32'd0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Bit-serial full adder: every {A,B,Cin} combination.
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 32'((i >> 2) & 1), 32'((i >> 1) & 1), 1'(i & 1), 1'b0, 1'b1, ok);
      measureLatency(0);
    end
    drain();

    // 8-bit, two chunks: carry and overflow corner cases for add and subtract.
    cur = 1;
    applyStimulus(1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b1, ok);
    measureLatency(1);
    applyStimulus(1, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, ok);
    measureLatency(1);
    applyStimulus(1, 32'h05, 32'h07, 1'b1, 1'b1, 1'b1, ok);
    measureLatency(1);
    applyStimulus(1, 32'h80, 32'h01, 1'b0, 1'b1, 1'b1, ok);
    measureLatency(1);
    drain();

    // 32-bit: full carry ripple, then backpressure hold and release.
    cur = 2;
    out_ready_v[2] = 1'b0;
    applyStimulus(2, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, ok);
    measureLatency(2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checkOutput("hold_S", s_w[2], 32'h1000_0000);
      checkOutput("hold_Cout", {31'b0, cout_w[2]}, 32'd0);
      checkOutput("hold_overflow", {31'b0, ovf_w[2]}, 32'd0);
      checkOutput("hold_out_valid", {31'b0, out_valid_w[2]}, 32'd1);
      checkOutput("hold_in_ready", {31'b0, in_ready_w[2]}, 32'd0);
    end
    out_ready_v[2] = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("release_in_ready", {31'b0, in_ready_w[2]}, 32'd1);
    checkOutput("release_out_valid", {31'b0, out_valid_w[2]}, 32'd0);
    drain();

    // Asynchronous reset in the middle of a 32-bit operation.
    applyStimulus(2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, ok);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", {31'b0, out_valid_w[2]}, 32'd0);
    checkOutput("abort_S", s_w[2], 32'd0);
    checkOutput("abort_in_ready", {31'b0, in_ready_w[2]}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(2, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, ok);
    measureLatency(2);
    drain();

    // Randomised runs with consumer stalls on both 16-bit configurations.
    for (int k = 3; k < 5; k++) begin
      cur       = k;
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        applyStimulus(k, ra & 32'hFFFF, rb & 32'hFFFF, 1'($urandom), 1'($urandom), 1'b1, ok);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
      end
      drain();
      rand_mode      = 1'b0;
      out_ready_v[k] = 1'b1;
      @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through an internal register between chunks.
- Successor to the single-bit full adder. It generalises width, adds a subtract mode and signed-overflow detection, and wraps the datapath in valid/ready handshakes so it can sit between pipeline stages of the ALU.
- A chunk of 1 gives a bit-serial adder; CHUNK = WIDTH gives a single-cycle registered adder.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- CHUNK, 4, bits summed per cycle; must divide WIDTH exactly.
- Derived N = WIDTH/CHUNK is the number of compute cycles. Elaboration fails via an error in a generate check if WIDTH % CHUNK != 0.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result held on S/Cout/overflow.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry out of MSB; for sub, 1 means no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, S=0, Cout=0, overflow=0, out_valid=0, in_ready=1.
  - Operand, carry and chunk-index registers are cleared.
  - Reset mid-RUN or mid-DONE aborts immediately and discards the operation.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on a clock edge with in_valid&in_ready:
  - latch A, latch B (B inverted if sub), latch carry (1 if sub, else Cin);
  - idx=0, go to RUN.
  - Inputs are sampled only at that edge; later input changes are ignored.
- RUN: each cycle computes chunk idx = A[idx*CHUNK +: CHUNK] + B'[idx*CHUNK +: CHUNK] + carry combinationally. At the edge:
  - write the sum into S[idx*CHUNK +: CHUNK];
  - update carry; idx++.
  - On the chunk for which idx = N-1:
    - also record carry into MSB (carry into bit WIDTH-1);
    - set Cout = final carry and overflow = carry_into_msb ^ final carry;
    - go to DONE.
  - S bits for chunks not yet computed hold their previous value and are not guaranteed during RUN.
- Latency: operands accepted at edge k → out_valid high after edge k+N. With CHUNK=WIDTH, N=1 and out_valid rises one cycle after accept.
- DONE: S/Cout/overflow stable while out_valid=1 and out_ready=0 (backpressure, unbounded hold).
  - On an edge with out_valid&out_ready → IDLE; in_ready=1 from the next cycle. No same-cycle accept in DONE.
  - Throughput: one operation per N+2 cycles at best.
- in_valid asserted during RUN/DONE is ignored (in_ready=0); the source must hold it.
- Arithmetic is modulo 2^WIDTH. Carry chaining is exact across chunk boundaries, so the result equals a WIDTH-bit ripple add.
- WIDTH=1, CHUNK=1: behaves as a registered full adder with overflow = Cin_eff ^ Cout.

Test Plan:
- WIDTH=1, CHUNK=1: apply all 8 {A,B,Cin} combos with sub=0, out_ready=1. Required: S=A^B^Cin and Cout=majority(A,B,Cin) for each. out_valid rises exactly 1 cycle after accept.
- WIDTH=8, CHUNK=4, unsigned add cases:
  - A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1, overflow=0, out_valid 2 cycles after accept.
  - A=0x7F, B=0x01 → S=0x80, Cout=0, overflow=1.
- WIDTH=8, CHUNK=4, subtract cases:
  - sub=1, A=0x05, B=0x07, Cin=1 (ignored) → S=0xFE, Cout=0, overflow=0.
  - sub=1, A=0x80, B=0x01 → S=0x7F, Cout=1, overflow=1.
- Default WIDTH=32, CHUNK=4, A=0x0FFFFFFF, B=0x00000001:
  - Required: S=0x10000000, Cout=0, out_valid 8 cycles after accept (carry ripples across all 7 chunk boundaries).
  - Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0 throughout.
  - Raise out_ready: in_ready=1 the following cycle.
- Drop reset_n asynchronously on RUN cycle 3 of a 32-bit add. Required:
  - out_valid=0, S=0 and in_ready=1 immediately.
  - After release, a new add of 3+4 returns S=7, with no residue from the aborted operation.
- Randomised at WIDTH=16, CHUNK=4 and WIDTH=16, CHUNK=16: 1000 random A/B/Cin/sub with random out_ready stalls. Required: S, Cout and overflow match a behavioural reference model each transaction.
